// File: rtl/io_sram_pkg.sv
// io_sram_pkg: shared types and helpers for the asynchronous-SRAM controller.
//   sram_state_t - controller FSM states
//   CntW         - width of the per-access latency counter (latencies 0..7)
//   merge_byte   - single-lane select used by the read-modify-write merge
package io_sram_pkg;

  localparam int unsigned CntW = 3;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StRmwRd,
    StWrite,
    StDone
  } sram_state_t;

  // Take the new write byte where its lane is enabled, otherwise keep the SRAM byte.
  function automatic logic [7:0] merge_byte(input logic       sel,
                                            input logic [7:0] wbyte,
                                            input logic [7:0] rbyte);
    return sel ? wbyte : rbyte;
  endfunction

endpackage

// File: rtl/io_sram_lane_merge.sv
// io_sram_lane_merge: combinational per-byte merge for read-modify-write.
//   be     - lane enables of the pending write (1 = take wdata)
//   wdata  - pending write data
//   dq_in  - word just read from the SRAM
//   merged - word to write back
module io_sram_lane_merge
  import io_sram_pkg::*;
#(
  parameter int unsigned BE_W = 4
) (
  input  logic [BE_W-1:0]   be,
  input  logic [8*BE_W-1:0] wdata,
  input  logic [8*BE_W-1:0] dq_in,
  output logic [8*BE_W-1:0] merged
);

  always_comb begin
    merged = '0;
    for (int i = 0; i < int'(BE_W); i++) begin
      merged[8*i +: 8] = merge_byte(be[i], wdata[8*i +: 8], dq_in[8*i +: 8]);
    end
  end

endmodule

// File: rtl/io_sram_ctrl.sv
// io_sram_ctrl: asynchronous-SRAM controller behind a level-held request bus.
//   clk, rst               - system clock; asynchronous active-high reset
//   req_rd / req_wr        - read / write request, held until ready
//   req_addr, req_be,
//   req_wdata              - word address, write byte enables, write data
//   rdata                  - read data, held until the next read capture
//   ready                  - one-cycle acknowledge
//   wr_pending             - a posted write is still running at the SRAM
//   sram_cs_b/oe_b/we_b    - active-low SRAM strobes
//   sram_be_b              - active-low lane enables
//   sram_addr              - SRAM address
//   sram_dq_out/sram_dq_oe - write data and output enable for the pad tristate
//   sram_dq_in             - data from the pads
// Partial writes use native lane enables when NATIVE_BE=1, otherwise a read-modify-write.
// With POST_WR=1 writes are acknowledged when accepted and finish in the background.
// All outputs are registered; reset releases the data bus immediately.
module io_sram_ctrl
  import io_sram_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned WR_LAT    = 1,
  parameter int unsigned NATIVE_BE = 0,
  parameter int unsigned POST_WR   = 0,
  localparam int unsigned BE_W     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [BE_W-1:0]   req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              wr_pending,
  output logic              sram_cs_b,
  output logic              sram_oe_b,
  output logic              sram_we_b,
  output logic [BE_W-1:0]   sram_be_b,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in
);

  localparam logic [CntW-1:0] RdCnt = CntW'(RD_LAT);
  localparam logic [CntW-1:0] WrCnt = CntW'(WR_LAT);

  sram_state_t     state_q;
  logic [CntW-1:0] cnt_q;
  logic [BE_W-1:0] be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merged;
  logic              direct_wr;

  // Full-word writes never need the read phase, whatever the SRAM supports.
  assign direct_wr = (NATIVE_BE != 0) || (&req_be);

  io_sram_lane_merge #(
    .BE_W(BE_W)
  ) u_lane_merge (
    .be    (be_q),
    .wdata (wdata_q),
    .dq_in (sram_dq_in),
    .merged(merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
      ready       <= 1'b0;
      wr_pending  <= 1'b0;
      sram_cs_b   <= 1'b1;
      sram_oe_b   <= 1'b1;
      sram_we_b   <= 1'b1;
      sram_be_b   <= '1;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state_q)
        StIdle: begin
          sram_cs_b  <= 1'b1;
          sram_oe_b  <= 1'b1;
          sram_we_b  <= 1'b1;
          sram_be_b  <= '1;
          sram_dq_oe <= 1'b0;
          if (req_rd || req_wr) begin
            sram_addr <= req_addr;
            be_q      <= req_be;
            wdata_q   <= req_wdata;
          end
          if (req_rd) begin
            sram_cs_b <= 1'b0;
            sram_oe_b <= 1'b0;
            sram_be_b <= '0;
            cnt_q     <= RdCnt;
            state_q   <= StRead;
          end else if (req_wr) begin
            if (direct_wr) begin
              sram_cs_b   <= 1'b0;
              sram_we_b   <= 1'b0;
              sram_be_b   <= (NATIVE_BE != 0) ? ~req_be : {BE_W{1'b0}};
              sram_dq_out <= req_wdata;
              sram_dq_oe  <= 1'b1;
              cnt_q       <= WrCnt;
              state_q     <= StWrite;
            end else begin
              sram_cs_b <= 1'b0;
              sram_oe_b <= 1'b0;
              sram_be_b <= '0;
              cnt_q     <= RdCnt;
              state_q   <= StRmwRd;
            end
            if (POST_WR != 0) begin
              ready      <= 1'b1;
              wr_pending <= 1'b1;
            end
          end
        end

        StRead: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rdata     <= sram_dq_in;
            sram_cs_b <= 1'b1;
            sram_oe_b <= 1'b1;
            sram_be_b <= '1;
            ready     <= 1'b1;
            state_q   <= StDone;
          end
        end

        StRmwRd: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            // oe goes high on the same edge dq_oe rises, so the bus never contends.
            sram_oe_b   <= 1'b1;
            sram_we_b   <= 1'b0;
            sram_dq_out <= merged;
            sram_dq_oe  <= 1'b1;
            cnt_q       <= WrCnt;
            state_q     <= StWrite;
          end
        end

        StWrite: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            sram_cs_b  <= 1'b1;
            sram_we_b  <= 1'b1;
            sram_be_b  <= '1;
            sram_dq_oe <= 1'b0;
            if (POST_WR != 0) begin
              wr_pending <= 1'b0;
              state_q    <= StIdle;
            end else begin
              ready   <= 1'b1;
              state_q <= StDone;
            end
          end
        end

        // One dead cycle so the request being dropped is not accepted again.
        StDone: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_io_sram_ctrl.sv
// Bench for io_sram_ctrl: three instances (RMW, native lanes, posted writes), each with its
// own SRAM model, checked against a word-array reference model and latency rules.
module tb_io_sram_ctrl;

  localparam int unsigned NI = 3;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;

  function automatic int unsigned rd_lat(input int unsigned g);
    return (g == 2) ? 2 : 1;
  endfunction
  function automatic int unsigned wr_lat(input int unsigned g);
    return (g == 2) ? 3 : 1;
  endfunction
  function automatic int unsigned native(input int unsigned g);
    return (g == 1) ? 1 : 0;
  endfunction
  function automatic int unsigned posted(input int unsigned g);
    return (g == 2) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req_rd     [NI];
  logic          req_wr     [NI];
  logic [AW-1:0] req_addr   [NI];
  logic [BW-1:0] req_be     [NI];
  logic [DW-1:0] req_wdata  [NI];
  logic [DW-1:0] rdata      [NI];
  logic          ready      [NI];
  logic          wr_pending [NI];
  logic          cs_b       [NI];
  logic          oe_b       [NI];
  logic          we_b       [NI];
  logic [BW-1:0] be_b       [NI];
  logic [AW-1:0] addr       [NI];
  logic [DW-1:0] dq_out     [NI];
  logic          dq_oe      [NI];
  logic [DW-1:0] dq_in      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    io_sram_ctrl #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .RD_LAT   (rd_lat(g)),
      .WR_LAT   (wr_lat(g)),
      .NATIVE_BE(native(g)),
      .POST_WR  (posted(g))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_rd     (req_rd[g]),
      .req_wr     (req_wr[g]),
      .req_addr   (req_addr[g]),
      .req_be     (req_be[g]),
      .req_wdata  (req_wdata[g]),
      .rdata      (rdata[g]),
      .ready      (ready[g]),
      .wr_pending (wr_pending[g]),
      .sram_cs_b  (cs_b[g]),
      .sram_oe_b  (oe_b[g]),
      .sram_we_b  (we_b[g]),
      .sram_be_b  (be_b[g]),
      .sram_addr  (addr[g]),
      .sram_dq_out(dq_out[g]),
      .sram_dq_oe (dq_oe[g]),
      .sram_dq_in (dq_in[g])
    );
  end

  // SRAM models: read while cs/oe low, write enabled lanes while cs/we low and bus driven.
  logic [DW-1:0] smem [NI][1 << AW];
  logic          pl_en = 1'b0;
  int            pl_g  = 0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always_comb begin
    for (int g = 0; g < int'(NI); g++) begin
      dq_in[g] = (!cs_b[g] && !oe_b[g]) ? smem[g][addr[g]] : '0;
    end
  end

  always @(posedge clk) begin
    if (pl_en) smem[pl_g][pl_addr] <= pl_data;
    for (int g = 0; g < int'(NI); g++) begin
      if (!cs_b[g] && !we_b[g] && dq_oe[g]) begin
        for (int b = 0; b < int'(BW); b++) begin
          if (!be_b[g][b]) smem[g][addr[g]][8*b +: 8] <= dq_out[g][8*b +: 8];
        end
      end
    end
  end

  // Strobe monitors, sampled mid-cycle.
  int oe_cnt  [NI] = '{0, 0, 0};
  int we_cnt  [NI] = '{0, 0, 0};
  int ovl_cnt [NI] = '{0, 0, 0};
  always @(negedge clk) begin
    for (int g = 0; g < int'(NI); g++) begin
      if (!oe_b[g]) oe_cnt[g] <= oe_cnt[g] + 1;
      if (!we_b[g]) we_cnt[g] <= we_cnt[g] + 1;
      if (!oe_b[g] && dq_oe[g]) ovl_cnt[g] <= ovl_cnt[g] + 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [DW-1:0] ref_mem [NI][1 << AW];
  int idle_at [NI] = '{0, 0, 0};
  int exp_oe  [NI] = '{0, 0, 0};
  int exp_we  [NI] = '{0, 0, 0};

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic preload(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_g    = g;
    pl_addr = a;
    pl_data = d;
    ref_mem[g][a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic check_reset(input int g, input string tag);
    chk($sformatf("%s_u%0d_cs_b", tag, g), cs_b[g], 1);
    chk($sformatf("%s_u%0d_oe_b", tag, g), oe_b[g], 1);
    chk($sformatf("%s_u%0d_we_b", tag, g), we_b[g], 1);
    chk($sformatf("%s_u%0d_be_b", tag, g), be_b[g], 4'hF);
    chk($sformatf("%s_u%0d_addr", tag, g), addr[g], 0);
    chk($sformatf("%s_u%0d_dq_out", tag, g), dq_out[g], 0);
    chk($sformatf("%s_u%0d_dq_oe", tag, g), dq_oe[g], 0);
    chk($sformatf("%s_u%0d_rdata", tag, g), rdata[g], 0);
    chk($sformatf("%s_u%0d_ready", tag, g), ready[g], 0);
    chk($sformatf("%s_u%0d_wr_pending", tag, g), wr_pending[g], 0);
  endtask

  task automatic check_strobes(input int g);
    chk($sformatf("u%0d_oe_cycles", g), oe_cnt[g], exp_oe[g]);
    chk($sformatf("u%0d_we_cycles", g), we_cnt[g], exp_we[g]);
    chk($sformatf("u%0d_oe_dq_overlap", g), ovl_cnt[g], 0);
  endtask

  // Present a request (called #1 after an edge), wait for ready, hold one more edge, drop.
  task automatic do_txn(input int g, input bit wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] be, input logic [DW-1:0] wd,
                        output logic [DW-1:0] rd, output int rdy_at, output logic wp);
    int k;
    req_addr[g]  = a;
    req_be[g]    = be;
    req_wdata[g] = wd;
    if (wr) req_wr[g] = 1'b1;
    else    req_rd[g] = 1'b1;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!ready[g] && k < 100);
    chk($sformatf("u%0d_ready_seen", g), ready[g], 1);
    rdy_at = cyc;
    rd     = rdata[g];
    wp     = wr_pending[g];
    @(posedge clk); #1;
    chk($sformatf("u%0d_ready_width", g), ready[g], 0);
    req_rd[g] = 1'b0;
    req_wr[g] = 1'b0;
  endtask

  task automatic run(input int g, input bit wr, input logic [AW-1:0] a,
                     input logic [BW-1:0] be, input logic [DW-1:0] wd);
    int first, acc, busy, lat, rdy_at;
    logic [DW-1:0] rd;
    logic wp;
    bit direct, post;
    direct = (native(g) != 0) || (be == 4'hF);
    post   = wr && (posted(g) != 0);
    first  = cyc + 1;
    acc    = (first > idle_at[g]) ? first : idle_at[g];
    if (!wr)        busy = rd_lat(g) + 1;
    else if (direct) busy = wr_lat(g) + 1;
    else            busy = rd_lat(g) + wr_lat(g) + 2;
    lat = post ? 0 : busy;
    do_txn(g, wr, a, be, wd, rd, rdy_at, wp);
    chk($sformatf("u%0d_latency_%s@%0h", g, wr ? "wr" : "rd", a), rdy_at, acc + lat);
    chk($sformatf("u%0d_wr_pending", g), wp, post);
    if (!wr) begin
      chk($sformatf("u%0d_rdata@%0h", g, a), rd, ref_mem[g][a]);
      exp_oe[g] += rd_lat(g) + 1;
    end else begin
      for (int b = 0; b < int'(BW); b++) begin
        if (be[b]) ref_mem[g][a][8*b +: 8] = wd[8*b +: 8];
      end
      if (!direct) exp_oe[g] += rd_lat(g) + 1;
      exp_we[g] += wr_lat(g) + 1;
    end
    idle_at[g] = post ? acc + busy + 1 : rdy_at + 2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit            wr;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    int            gap;

    for (int g = 0; g < int'(NI); g++) begin
      req_rd[g]    = 1'b0;
      req_wr[g]    = 1'b0;
      req_addr[g]  = '0;
      req_be[g]    = '0;
      req_wdata[g] = '0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < int'(NI); g++) check_reset(g, "reset");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Instance 0: RMW emulation, RD_LAT=1, WR_LAT=1.
    preload(0, 'h010, 32'hDEADBEEF);
    run(0, 1'b0, 'h010, 4'h0, 32'h0);
    preload(0, 'h020, 32'h11223344);
    run(0, 1'b1, 'h020, 4'b0101, 32'hAABBCCDD);
    run(0, 1'b0, 'h020, 4'h0, 32'h0);
    check_strobes(0);

    // Instance 1: native lanes.
    preload(1, 'h020, 32'h11223344);
    run(1, 1'b1, 'h020, 4'b0101, 32'hAABBCCDD);
    run(1, 1'b0, 'h020, 4'h0, 32'h0);
    check_strobes(1);

    // Instance 2: posted writes, RD_LAT=2, WR_LAT=3, RMW for partials.
    run(2, 1'b1, 'h030, 4'hF, 32'h12345678);
    run(2, 1'b0, 'h030, 4'h0, 32'h0);
    preload(2, 'h050, 32'hCAFEF00D);
    run(2, 1'b1, 'h050, 4'b1000, 32'h99000000);
    run(2, 1'b0, 'h050, 4'h0, 32'h0);
    run(2, 1'b1, 'h031, 4'hF, 32'h0BADC0DE);
    run(2, 1'b1, 'h030, 4'b0010, 32'h0000EE00);
    run(2, 1'b0, 'h031, 4'h0, 32'h0);
    run(2, 1'b0, 'h030, 4'h0, 32'h0);
    check_strobes(2);

    // Randomized traffic over a preloaded window.
    for (int g = 0; g < int'(NI); g++) begin
      for (int i = 0; i < 16; i++) preload(g, AW'('h100 + i), $urandom);
    end
    for (int g = 0; g < int'(NI); g++) begin
      repeat (30) begin
        wr = ($urandom_range(0, 9) < 5);
        a  = AW'('h100 + $urandom_range(0, 15));
        be = ($urandom_range(0, 3) == 0) ? 4'hF : BW'($urandom);
        run(g, wr, a, be, $urandom);
        gap = $urandom_range(0, 2);
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
    repeat (20) @(posedge clk);
    #1;
    for (int g = 0; g < int'(NI); g++) check_strobes(g);

    // Reset in the middle of an RMW read phase on instance 0.
    preload(0, 'h040, 32'h55667788);
    req_addr[0]  = 'h040;
    req_be[0]    = 4'b0011;
    req_wdata[0] = 32'hFFFFFFFF;
    req_wr[0]    = 1'b1;
    @(posedge clk); #1;
    chk("rmw_oe_active", oe_b[0], 0);
    chk("rmw_dq_oe_idle", dq_oe[0], 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset(0, "midrmw");
    req_wr[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("midrmw_sram_word", smem[0]['h040], ref_mem[0]['h040]);
    idle_at[0] = 0;
    run(0, 1'b0, 'h040, 4'h0, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
